// File: rtl/snn_spike_pkg.sv
// Shared 48-bit spike event format: field offsets, valid-byte constant and pack/unpack helpers.
package snn_spike_pkg;

    localparam int unsigned EventWidth = 48;
    localparam int unsigned ValidLsb   = 0;
    localparam int unsigned XLsb       = 8;
    localparam int unsigned YLsb       = 16;
    localparam int unsigned ChLsb      = 24;
    localparam int unsigned TsLsb      = 32;

    localparam logic [7:0] ValidByte = 8'h01;

    typedef struct packed {
        logic [15:0] ts;
        logic [7:0]  ch;
        logic [7:0]  y;
        logic [7:0]  x;
        logic [7:0]  valid;
    } spike_evt_t;

    function automatic logic [EventWidth-1:0] pack_evt(input spike_evt_t e);
        logic [EventWidth-1:0] d;
        d                 = '0;
        d[TsLsb+:16]      = e.ts;
        d[ChLsb+:8]       = e.ch;
        d[YLsb+:8]        = e.y;
        d[XLsb+:8]        = e.x;
        d[ValidLsb+:8]    = e.valid;
        return d;
    endfunction

    function automatic spike_evt_t unpack_evt(input logic [EventWidth-1:0] d);
        spike_evt_t e;
        e.ts    = d[TsLsb+:16];
        e.ch    = d[ChLsb+:8];
        e.y     = d[YLsb+:8];
        e.x     = d[XLsb+:8];
        e.valid = d[ValidLsb+:8];
        return e;
    endfunction

endpackage

// File: rtl/snn_upsample_coord_gen.sv
// dx/dy offset counters for one SCALE x SCALE block, raster order with dx fastest.
module snn_upsample_coord_gen #(
    parameter int unsigned SCALE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       advance_i,
    output logic [2:0] dx_o,
    output logic [2:0] dy_o,
    output logic [2:0] dx_next_o,
    output logic [2:0] dy_next_o,
    output logic       last_o,
    output logic       last_next_o
);

    localparam logic [2:0] Max = 3'(SCALE - 1);

    logic [2:0] dx_q, dy_q;
    logic       dx_wrap;

    always_comb begin
        dx_wrap   = (dx_q == Max);
        dx_next_o = dx_wrap ? 3'd0 : dx_q + 3'd1;
        dy_next_o = dy_q;
        if (dx_wrap) begin
            dy_next_o = (dy_q == Max) ? 3'd0 : dy_q + 3'd1;
        end
        last_o      = dx_wrap && (dy_q == Max);
        last_next_o = (dx_next_o == Max) && (dy_next_o == Max);
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            dx_q <= 3'd0;
            dy_q <= 3'd0;
        end else if (advance_i) begin
            dx_q <= dx_next_o;
            dy_q <= dy_next_o;
        end
    end

    assign dx_o = dx_q;
    assign dy_o = dy_q;

endmodule

// File: rtl/snn_upsample2d.sv
// Spike-stream nearest-neighbour upsampler: each input event becomes SCALE x SCALE output events.
// Optional input filtering via `define SNN_UPSAMPLE_DROP_INVALID_EN.
module snn_upsample2d
    import snn_spike_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH    = 14,
    parameter int unsigned INPUT_HEIGHT   = 14,
    parameter int unsigned INPUT_CHANNELS = 32,
    parameter int unsigned SCALE          = 2,
    parameter int unsigned TIME_WIDTH     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [47:0] s_axis_input_tdata,
    input  logic        s_axis_input_tvalid,
    output logic        s_axis_input_tready,
    input  logic        s_axis_input_tlast,
    output logic [47:0] m_axis_output_tdata,
    output logic        m_axis_output_tvalid,
    input  logic        m_axis_output_tready,
    output logic        m_axis_output_tlast,
    output logic [31:0] input_spike_count,
    output logic [31:0] output_spike_count,
    output logic [31:0] dropped_count,
    output logic        busy
);

    typedef enum logic [0:0] {StIdle, StExpand} state_e;

    localparam logic [7:0] ScaleB     = 8'(SCALE);
    localparam logic       ScaleIsOne = (SCALE == 1);

    state_e                  state_q, state_d;
    logic [TIME_WIDTH-1:0]   ts_q;
    logic [7:0]              ch_q, base_x_q, base_y_q;
    logic                    in_last_q;
    logic                    tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [EventWidth-1:0]   tdata_q, tdata_d;
    logic [31:0]             in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
    logic                    latch, advance, in_hs, out_hs, evt_ok;
    logic [7:0]              in_base_x, in_base_y;
    logic [2:0]              dx, dy, dx_next, dy_next;
    logic                    last, last_next;
    spike_evt_t              in_evt;

    function automatic logic [EventWidth-1:0] make_beat(input logic [15:0] ts, input logic [7:0] ch,
                                                        input logic [7:0] by, input logic [7:0] bx,
                                                        input logic [2:0] oy, input logic [2:0] ox);
        spike_evt_t e;
        e.ts    = ts;
        e.ch    = ch;
        e.y     = by + {5'd0, oy};
        e.x     = bx + {5'd0, ox};
        e.valid = ValidByte;
        return pack_evt(e);
    endfunction

    assign in_evt    = unpack_evt(s_axis_input_tdata);
    assign in_base_x = in_evt.x * ScaleB;
    assign in_base_y = in_evt.y * ScaleB;

    assign s_axis_input_tready = ~reset & enable & (state_q == StIdle);
    assign in_hs  = s_axis_input_tready & s_axis_input_tvalid;
    assign out_hs = tvalid_q & m_axis_output_tready;

`ifdef SNN_UPSAMPLE_DROP_INVALID_EN
    // Widen to 9 bits so a dimension of 256 still compares correctly.
    assign evt_ok = (in_evt.valid != 8'h00)
                 && ({1'b0, in_evt.x}  < 9'(INPUT_WIDTH))
                 && ({1'b0, in_evt.y}  < 9'(INPUT_HEIGHT))
                 && ({1'b0, in_evt.ch} < 9'(INPUT_CHANNELS));
    assign dropped_count = drop_cnt_q;
`else
    logic unused_cfg;
    assign evt_ok        = 1'b1;
    assign dropped_count = 32'd0;
    assign unused_cfg    = (^{in_evt.valid, drop_cnt_q})
                         ^ ((INPUT_WIDTH + INPUT_HEIGHT + INPUT_CHANNELS) == 0);
`endif

    snn_upsample_coord_gen #(
        .SCALE (SCALE)
    ) u_coord (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (latch),
        .advance_i   (advance),
        .dx_o        (dx),
        .dy_o        (dy),
        .dx_next_o   (dx_next),
        .dy_next_o   (dy_next),
        .last_o      (last),
        .last_next_o (last_next)
    );

    always_comb begin
        state_d    = state_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;
        latch      = 1'b0;
        advance    = 1'b0;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (out_hs) begin
            out_cnt_d = out_cnt_q + 32'd1;
        end
        case (state_q)
            StIdle: begin
                if (in_hs) begin
                    in_cnt_d = in_cnt_q + 32'd1;
                    if (evt_ok) begin
                        latch    = 1'b1;
                        state_d  = StExpand;
                        tvalid_d = 1'b1;
                        tdata_d  = make_beat(in_evt.ts, in_evt.ch, in_base_y, in_base_x,
                                             3'd0, 3'd0);
                        tlast_d  = s_axis_input_tlast & ScaleIsOne;
                    end else begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end
                end
            end
            StExpand: begin
                if (out_hs) begin
                    if (last) begin
                        state_d  = StIdle;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end else begin
                        advance  = 1'b1;
                        tvalid_d = enable;
                        tdata_d  = make_beat(16'(ts_q), ch_q, base_y_q, base_x_q, dy_next, dx_next);
                        tlast_d  = enable & in_last_q & last_next;
                    end
                end else if (!tvalid_q && enable) begin
                    // Resume after an enable-low pause at the coordinate not yet presented.
                    tvalid_d = 1'b1;
                    tdata_d  = make_beat(16'(ts_q), ch_q, base_y_q, base_x_q, dy, dx);
                    tlast_d  = in_last_q & last;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            in_cnt_q   <= 32'd0;
            out_cnt_q  <= 32'd0;
            drop_cnt_q <= 32'd0;
            ts_q       <= '0;
            ch_q       <= 8'd0;
            base_x_q   <= 8'd0;
            base_y_q   <= 8'd0;
            in_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            if (latch) begin
                ts_q      <= TIME_WIDTH'(in_evt.ts);
                ch_q      <= in_evt.ch;
                base_x_q  <= in_base_x;
                base_y_q  <= in_base_y;
                in_last_q <= s_axis_input_tlast;
            end
        end
    end

    assign m_axis_output_tdata  = tdata_q;
    assign m_axis_output_tvalid = tvalid_q;
    assign m_axis_output_tlast  = tlast_q;
    assign input_spike_count    = in_cnt_q;
    assign output_spike_count   = out_cnt_q;
    assign busy                 = (state_q == StExpand);

endmodule

// File: doc/snn_upsample2d.md
# snn_upsample2d

Spike-domain 2D nearest-neighbour upsampling layer: the expanding counterpart to the spike max-pooling stage. Each accepted input spike event on the 48-bit spike AXI-Stream is replicated into SCALE×SCALE output spike events covering the corresponding upsampled block. Channel and timestamp are preserved. Sits in decoder or transposed paths between spike-stream layers and uses the same event format on both sides.

## Interface
- INPUT_WIDTH, 14 — input map width; INPUT_WIDTH*SCALE ≤ 256
- INPUT_HEIGHT, 14 — input map height; INPUT_HEIGHT*SCALE ≤ 256
- INPUT_CHANNELS, 32 — channel count; ≤ 256
- SCALE, 2 — upsampling factor; 1..8
- TIME_WIDTH, 16 — timestamp width; fixed at 16 by the event format
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  run enable
- s_axis_input_tdata  in  48  {timestamp[15:0], channel[7:0], y[7:0], x[7:0], valid[7:0]}
- s_axis_input_tvalid  in  1  input beat valid
- s_axis_input_tready  out  1  input ready
- s_axis_input_tlast  in  1  end of input frame
- m_axis_output_tdata  out  48  same format; valid byte always 8'h01
- m_axis_output_tvalid  out  1  output beat valid
- m_axis_output_tready  in  1  downstream ready
- m_axis_output_tlast  out  1  end of output frame
- input_spike_count  out  32  accepted input beats
- output_spike_count  out  32  completed output handshakes
- dropped_count  out  32  dropped input beats (0 when macro absent)
- busy  out  1  expansion in progress

## Operation
- FSM states are IDLE and EXPAND.
- IDLE: s_axis_input_tready = enable. On handshake, latch ts, ch, base_x = x*SCALE, base_y = y*SCALE, and in_last. Clear dx and dy, then go to EXPAND.
- EXPAND: present {ts, ch, base_y+dy, base_x+dx, 8'h01}. Order is raster with dx fastest. On each output handshake, advance dx; when dx wraps (SCALE−1→0), advance dy.
- m_axis_output_tlast = in_last && dx==SCALE−1 && dy==SCALE−1.
- After the handshake on the final beat (dx=dy=SCALE−1), go to IDLE.
- Coordinate arithmetic is 8-bit unsigned. The parameter constraints guarantee no overflow.
- enable low:
  - tready is deasserted.
  - A beat already presented holds tvalid and its data until accepted (AXI rule).
  - No further beats are generated until enable returns.
- Counters increment by 1 per event and wrap modulo 2^32.
- busy = (state == EXPAND).

## Timing
- Reset values:
  - tready 0 in the reset cycle, then equal to enable.
  - tvalid 0, tlast 0, tdata 0.
  - All counters 0, busy 0, state IDLE.
- Latency: input handshake in cycle N gives the first output tvalid in cycle N+1.
- Throughput: one output beat per cycle while tready is held high. One input is accepted every SCALE²+1 cycles.
- Output data, tvalid and tlast are registered and remain stable while tvalid && !tready.
- Reset mid-EXPAND discards the in-flight expansion. tvalid drops on the cycle after reset is sampled.
- An input beat with tvalid but tready low is ignored and not counted.

## Configuration
- SNN_UPSAMPLE_DROP_INVALID_EN
  - Defined:
    - An accepted beat is dropped when its valid byte is 0, x ≥ INPUT_WIDTH, y ≥ INPUT_HEIGHT, or channel ≥ INPUT_CHANNELS.
    - A dropped beat produces no output, increments dropped_count and input_spike_count, and the FSM stays in IDLE.
    - A dropped beat carrying tlast is lost; no tlast is emitted for it.
  - Undefined: every accepted beat is expanded unchecked, and dropped_count is tied to 0.

## Structure
- Shared package snn_spike_pkg holds:
  - Event width (48) and field bit offsets.
  - Valid-byte constant 8'h01.
  - A pack/unpack function pair for the event format.
- One sub-module, snn_upsample_coord_gen, holds the dx/dy counters with advance, wrap and last-beat flag.

## Test plan
- Basic expansion:
  - Stimulus: SCALE=2, tready=1, input {ts=0x0010, ch=3, y=4, x=5, valid=1} accepted in cycle N.
  - Required: outputs (x,y) = (10,8), (11,8), (10,9), (11,9) in cycles N+1..N+4, all with ch=3, ts=0x0010, valid=8'h01. busy falls and tready reasserts in cycle N+5.
- Backpressure:
  - Stimulus: same input, tready toggled 1,0,0,1,1,0,1.
  - Required: the beat sequence is unchanged, and data is stable during every stall. output_spike_count reaches 4.
- Frame end:
  - Stimulus: two inputs, the second with tlast=1.
  - Required: tlast asserted only on output beat 8. input_spike_count=2, output_spike_count=8.
- SCALE=3:
  - Stimulus: input x=0, y=0, ch=0.
  - Required: 9 beats covering x,y ∈ {0,1,2}, raster order with x fastest.
- Drop (macro defined):
  - Stimulus: a beat with valid=0, then a beat with x=14.
  - Required: no output, dropped_count=2, input_spike_count=2.
- Reset mid-EXPAND:
  - Stimulus: assert reset after the 2nd of 4 output beats.
  - Required: tvalid=0 and all counters 0 next cycle. A fresh input afterwards expands correctly from (base_x, base_y).
